// File: rtl/video_mux_pkg.sv
// Shared types and helpers for the frame-safe N-channel video source selector.
package video_mux_pkg;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  // Widest channel bus / pixel the slice helper handles (16 channels x 64 bits).
  localparam int MAX_BUS_W  = 1024;
  localparam int MAX_DATA_W = 64;

  function automatic logic blank_sync(input logic pol);
    return ~pol;
  endfunction

  function automatic logic [MAX_DATA_W-1:0] ch_slice(input logic [MAX_BUS_W-1:0] bus,
                                                     input int k, input int w);
    return MAX_DATA_W'(bus >> (k * w));
  endfunction

endpackage

// File: rtl/vs_boundary_det.sv
// Per-channel frame boundary detector: flags the trailing edge of each vsync pulse.
module vs_boundary_det
  import video_mux_pkg::*;
#(
  parameter int C_NUM_CH           = 4,
  parameter bit C_SYNC_ACTIVE_HIGH = 1'b0
) (
  input  logic                pix_clk,
  input  logic                reset,
  input  logic [C_NUM_CH-1:0] vs_in,
  output logic [C_NUM_CH-1:0] bnd
);

  localparam logic IDLE = blank_sync(C_SYNC_ACTIVE_HIGH);

  logic [C_NUM_CH-1:0] vs_d;

  always_ff @(posedge pix_clk or posedge reset) begin
    if (reset) vs_d <= {C_NUM_CH{IDLE}};
    else       vs_d <= vs_in;
  end

  // Combinational on the live input so the FSM reacts on the edge that ends the pulse.
  always_comb begin
    bnd = '0;
    for (int k = 0; k < C_NUM_CH; k++) begin
      bnd[k] = (vs_d[k] != IDLE) && (vs_in[k] == IDLE);
    end
  end

endmodule

// File: rtl/video_src_mux.sv
// Frame-safe N-channel video source selector: switches only on frame boundaries,
// with a blanked gap between sources and a watchdog for a target that never frames.
module video_src_mux
  import video_mux_pkg::*;
#(
  parameter int C_DATA_WIDTH       = 20,
  parameter int C_NUM_CH           = 4,
  parameter int C_SEL_W            = 2,
  parameter bit C_SYNC_ACTIVE_HIGH = 1'b0,
  parameter int C_TIMEOUT_CYC      = 16777215
) (
  input  logic                             pix_clk,
  input  logic                             reset,
  input  logic [C_SEL_W-1:0]               sel,
  input  logic [C_NUM_CH-1:0]              vs_in,
  input  logic [C_NUM_CH-1:0]              hs_in,
  input  logic [C_NUM_CH-1:0]              de_in,
  input  logic [C_NUM_CH*C_DATA_WIDTH-1:0] data_in,
  output logic                             vs_o,
  output logic                             hs_o,
  output logic                             de_o,
  output logic [C_DATA_WIDTH-1:0]          data_o,
  output logic [C_SEL_W-1:0]               active_ch,
  output logic                             switching,
  output logic                             src_lost
);

  localparam logic IDLE  = blank_sync(C_SYNC_ACTIVE_HIGH);
  localparam int   N_IDX = 1 << C_SEL_W;
  localparam int   WD_W  = (C_TIMEOUT_CYC > 1) ? $clog2(C_TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((C_TIMEOUT_CYC > 0) ? C_TIMEOUT_CYC - 1 : 0);

  logic [C_SEL_W-1:0]      sel_meta, sel_s;
  logic                    sel_valid;
  logic [C_NUM_CH-1:0]     bnd;
  logic [N_IDX-1:0]        bnd_idx, vs_idx, hs_idx, de_idx;
  logic [MAX_BUS_W-1:0]    data_bus;
  logic [C_DATA_WIDTH-1:0] data_sel;
  state_t                  state;
  logic [C_SEL_W-1:0]      cur, tgt;
  logic [WD_W-1:0]         wd;

  always_ff @(posedge pix_clk or posedge reset) begin
    if (reset) begin
      sel_meta <= '0;
      sel_s    <= '0;
    end else begin
      sel_meta <= sel;
      sel_s    <= sel_meta;
    end
  end

  assign sel_valid = (int'(sel_s) < C_NUM_CH);

  vs_boundary_det #(
    .C_NUM_CH           (C_NUM_CH),
    .C_SYNC_ACTIVE_HIGH (C_SYNC_ACTIVE_HIGH)
  ) u_bnd (
    .pix_clk (pix_clk),
    .reset   (reset),
    .vs_in   (vs_in),
    .bnd     (bnd)
  );

  // Pad per-channel vectors to the full index range so cur/tgt index them exactly.
  assign bnd_idx  = N_IDX'(bnd);
  assign vs_idx   = N_IDX'(vs_in);
  assign hs_idx   = N_IDX'(hs_in);
  assign de_idx   = N_IDX'(de_in);
  assign data_bus = MAX_BUS_W'(data_in);
  assign data_sel = C_DATA_WIDTH'(ch_slice(data_bus, int'(cur), C_DATA_WIDTH));

  always_ff @(posedge pix_clk or posedge reset) begin
    if (reset) begin
      state     <= ST_INIT;
      cur       <= '0;
      tgt       <= '0;
      wd        <= '0;
      active_ch <= '0;
      switching <= 1'b1;
      src_lost  <= 1'b0;
    end else begin
      src_lost  <= 1'b0;
      switching <= 1'b1;
      unique case (state)
        ST_INIT: begin
          state <= ST_GAP;
          tgt   <= sel_valid ? sel_s : '0;
          wd    <= '0;
        end
        ST_LOCKED: begin
          if (sel_valid && (sel_s != cur)) begin
            state <= ST_DRAIN;
            tgt   <= sel_s;
          end else begin
            switching <= 1'b0;
          end
        end
        // A cancel wins over the boundary, so the old source runs on without a blank.
        ST_DRAIN: begin
          if (sel_s == cur) begin
            state     <= ST_LOCKED;
            switching <= 1'b0;
          end else if (sel_valid && (sel_s != tgt)) begin
            tgt <= sel_s;
          end else if (bnd_idx[cur]) begin
            state <= ST_GAP;
            wd    <= '0;
          end
        end
        ST_GAP: begin
          if (sel_valid && (sel_s != tgt)) begin
            tgt <= sel_s;
            wd  <= '0;
          end else if (bnd_idx[tgt]) begin
            state     <= ST_LOCKED;
            cur       <= tgt;
            active_ch <= tgt;
            switching <= 1'b0;
          end else if ((C_TIMEOUT_CYC != 0) && (wd == WD_LAST)) begin
            src_lost <= 1'b1;
            wd       <= '0;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
      endcase
    end
  end

  // Output choice follows the pre-edge state, so the sample that exits GAP is blank.
  always_ff @(posedge pix_clk or posedge reset) begin
    if (reset) begin
      vs_o   <= IDLE;
      hs_o   <= IDLE;
      de_o   <= 1'b0;
      data_o <= '0;
    end else if ((state == ST_LOCKED) || (state == ST_DRAIN)) begin
      vs_o   <= vs_idx[cur];
      hs_o   <= hs_idx[cur];
      de_o   <= de_idx[cur];
      data_o <= data_sel;
    end else begin
      vs_o   <= IDLE;
      hs_o   <= IDLE;
      de_o   <= 1'b0;
      data_o <= '0;
    end
  end

endmodule

// File: tb/tb_video_src_mux.sv
// Bench for video_src_mux: small synthetic video sources with random pixels, compared
// every cycle against a behavioural model of the selector's switching rules.
module tb_video_src_mux;

  localparam int W   = 20;
  localparam int N   = 4;
  localparam int SW  = 3;
  localparam int TMO = 100;

  localparam int R_INIT = 0, R_LOCKED = 1, R_DRAIN = 2, R_GAP = 3;

  logic          pix_clk = 1'b0;
  logic          reset;
  logic [SW-1:0] sel;
  logic [N-1:0]  vs_in, hs_in, de_in;
  logic [N*W-1:0] data_in;
  logic          vs_o, hs_o, de_o;
  logic [W-1:0]  data_o;
  logic [SW-1:0] active_ch;
  logic          switching, src_lost;

  video_src_mux #(
    .C_DATA_WIDTH       (W),
    .C_NUM_CH           (N),
    .C_SEL_W            (SW),
    .C_SYNC_ACTIVE_HIGH (1'b0),
    .C_TIMEOUT_CYC      (TMO)
  ) dut (
    .pix_clk   (pix_clk),
    .reset     (reset),
    .sel       (sel),
    .vs_in     (vs_in),
    .hs_in     (hs_in),
    .de_in     (de_in),
    .data_in   (data_in),
    .vs_o      (vs_o),
    .hs_o      (hs_o),
    .de_o      (de_o),
    .data_o    (data_o),
    .active_ch (active_ch),
    .switching (switching),
    .src_lost  (src_lost)
  );

  always #5 pix_clk = ~pix_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int gap_de = 0;

  int h_tot [N];
  int v_tot [N];
  int pos   [N];
  bit stuck [N];

  int r_mode, r_prev_mode, r_cur, r_tgt, r_wd, r_sel_meta, r_sel_s;
  logic [N-1:0] r_prev_vs;
  logic e_vs, e_hs, e_de, e_sw, e_lost;
  logic [W-1:0] e_data;
  int e_active;

  // Sources: vsync low for line 0, hsync low for 2 pixels, de on lines >= 1.
  task automatic refresh_inputs();
    for (int k = 0; k < N; k++) begin
      int h;
      int v;
      h = pos[k] % h_tot[k];
      v = pos[k] / h_tot[k];
      vs_in[k] = stuck[k] || (v != 0);
      hs_in[k] = (h >= 2);
      de_in[k] = (v >= 1) && (h >= 3) && (h < h_tot[k] - 1);
      data_in[k*W +: W] = W'($urandom);
    end
  endtask

  task automatic advance_inputs();
    for (int k = 0; k < N; k++) pos[k] = (pos[k] + 1) % (h_tot[k] * v_tot[k]);
    refresh_inputs();
  endtask

  // Edges remaining until channel k presents the first sample after its vsync pulse.
  function automatic int to_bnd(int k);
    int tot;
    tot = h_tot[k] * v_tot[k];
    return (h_tot[k] - pos[k] + tot) % tot;
  endfunction

  task automatic model_reset();
    r_mode = R_INIT; r_prev_mode = R_INIT;
    r_cur = 0; r_tgt = 0; r_wd = 0; r_sel_meta = 0; r_sel_s = 0;
    r_prev_vs = '1;
    e_vs = 1'b1; e_hs = 1'b1; e_de = 1'b0; e_data = '0;
    e_active = 0; e_sw = 1'b1; e_lost = 1'b0;
  endtask

  task automatic model_edge();
    logic [N-1:0] b;
    bit valid;
    for (int k = 0; k < N; k++) b[k] = !r_prev_vs[k] && vs_in[k];
    valid = (r_sel_s < N);
    r_prev_mode = r_mode;
    if (r_mode == R_LOCKED || r_mode == R_DRAIN) begin
      e_vs = vs_in[r_cur]; e_hs = hs_in[r_cur]; e_de = de_in[r_cur];
      e_data = data_in[r_cur*W +: W];
    end else begin
      e_vs = 1'b1; e_hs = 1'b1; e_de = 1'b0; e_data = '0;
    end
    e_lost = 1'b0;
    if (r_mode == R_INIT) begin
      r_tgt = valid ? r_sel_s : 0;
      r_mode = R_GAP;
      r_wd = 0;
    end else if (r_mode == R_LOCKED) begin
      if (valid && r_sel_s != r_cur) begin r_mode = R_DRAIN; r_tgt = r_sel_s; end
    end else if (r_mode == R_DRAIN) begin
      if (r_sel_s == r_cur) r_mode = R_LOCKED;
      else if (valid && r_sel_s != r_tgt) r_tgt = r_sel_s;
      else if (b[r_cur]) begin r_mode = R_GAP; r_wd = 0; end
    end else begin
      if (valid && r_sel_s != r_tgt) begin r_tgt = r_sel_s; r_wd = 0; end
      else if (b[r_tgt]) begin r_mode = R_LOCKED; r_cur = r_tgt; end
      else if (r_wd == TMO - 1) begin e_lost = 1'b1; r_wd = 0; end
      else r_wd = r_wd + 1;
    end
    e_active = r_cur;
    e_sw = (r_mode != R_LOCKED);
    r_sel_s = r_sel_meta;
    r_sel_meta = int'(sel);
    r_prev_vs = vs_in;
  endtask

  task automatic run_cycle();
    @(posedge pix_clk);
    model_edge();
    cyc++;
    #1;
    total++; if (vs_o !== e_vs) begin bad++; $display("[TB] FAIL vs_o cyc=%0d got=%0b exp=%0b", cyc, vs_o, e_vs); end
    total++; if (hs_o !== e_hs) begin bad++; $display("[TB] FAIL hs_o cyc=%0d got=%0b exp=%0b", cyc, hs_o, e_hs); end
    total++; if (de_o !== e_de) begin bad++; $display("[TB] FAIL de_o cyc=%0d got=%0b exp=%0b", cyc, de_o, e_de); end
    total++; if (data_o !== e_data) begin bad++; $display("[TB] FAIL data_o cyc=%0d got=%0h exp=%0h", cyc, data_o, e_data); end
    total++; if (active_ch !== SW'(e_active)) begin bad++; $display("[TB] FAIL active_ch cyc=%0d got=%0d exp=%0d", cyc, active_ch, e_active); end
    total++; if (switching !== e_sw) begin bad++; $display("[TB] FAIL switching cyc=%0d got=%0b exp=%0b", cyc, switching, e_sw); end
    total++; if (src_lost !== e_lost) begin bad++; $display("[TB] FAIL src_lost cyc=%0d got=%0b exp=%0b", cyc, src_lost, e_lost); end
    if (de_o === 1'b1 && (r_prev_mode == R_GAP || r_prev_mode == R_INIT)) gap_de++;
    advance_inputs();
  endtask

  task automatic wait_lock(input int ch, input string name);
    int n;
    n = 0;
    while (!(r_mode == R_LOCKED && r_cur == ch) && n < 2000) begin
      run_cycle();
      n++;
    end
    total++; if (n >= 2000) begin bad++; $display("[TB] FAIL %s_timeout got=%0d cycles exp=<2000", name, n); end
    total++; if (active_ch !== SW'(ch)) begin bad++; $display("[TB] FAIL %s_active got=%0d exp=%0d", name, active_ch, ch); end
    total++; if (switching !== 1'b0) begin bad++; $display("[TB] FAIL %s_switching got=%0b exp=0", name, switching); end
  endtask

  task automatic wait_gap(input string name);
    int n;
    n = 0;
    while (r_mode != R_GAP && n < 1000) begin run_cycle(); n++; end
    total++; if (n >= 1000) begin bad++; $display("[TB] FAIL %s_gap_timeout got=%0d exp=<1000", name, n); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sel = 3'd2;
    for (int k = 0; k < N; k++) begin
      h_tot[k] = 10 + 2 * k;
      v_tot[k] = 5 + k;
      pos[k] = (k * 17) % (h_tot[k] * v_tot[k]);
      stuck[k] = 1'b0;
    end
    refresh_inputs();
    model_reset();
    repeat (3) begin @(posedge pix_clk); #1; advance_inputs(); end
    total++; if (vs_o !== 1'b1) begin bad++; $display("[TB] FAIL rst_vs got=%0b exp=1", vs_o); end
    total++; if (hs_o !== 1'b1) begin bad++; $display("[TB] FAIL rst_hs got=%0b exp=1", hs_o); end
    total++; if (de_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_de got=%0b exp=0", de_o); end
    total++; if (data_o !== '0) begin bad++; $display("[TB] FAIL rst_data got=%0h exp=0", data_o); end
    total++; if (active_ch !== '0) begin bad++; $display("[TB] FAIL rst_active got=%0d exp=0", active_ch); end
    total++; if (switching !== 1'b1) begin bad++; $display("[TB] FAIL rst_switching got=%0b exp=1", switching); end
    total++; if (src_lost !== 1'b0) begin bad++; $display("[TB] FAIL rst_lost got=%0b exp=0", src_lost); end
    reset = 1'b0;
    wait_lock(2, "reset_lock");
  endtask

  task automatic test_switch();
    sel = 3'd0;
    wait_lock(0, "to_ch0");
    repeat ($urandom_range(5, 30)) run_cycle();
    gap_de = 0;
    sel = 3'd3;
    wait_lock(3, "to_ch3");
    total++; if (gap_de !== 0) begin bad++; $display("[TB] FAIL switch_gap_de got=%0d exp=0", gap_de); end
  endtask

  task automatic test_cancel();
    int n;
    sel = 3'd1;
    wait_lock(1, "cancel_pre");
    n = 0;
    while (to_bnd(1) != 6 && n < 500) begin run_cycle(); n++; end
    sel = 3'd2;
    repeat (4) run_cycle();
    total++; if (switching !== 1'b1) begin bad++; $display("[TB] FAIL cancel_drain got=%0b exp=1", switching); end
    sel = 3'd1;
    repeat (8) run_cycle();
    total++; if (switching !== 1'b0) begin bad++; $display("[TB] FAIL cancel_locked got=%0b exp=0", switching); end
    total++; if (active_ch !== 3'd1) begin bad++; $display("[TB] FAIL cancel_active got=%0d exp=1", active_ch); end
  endtask

  task automatic test_retarget();
    int n;
    stuck[2] = 1'b1;
    refresh_inputs();
    sel = 3'd2;
    wait_gap("retarget");
    n = 0;
    while (to_bnd(2) < 3 && n < 10) begin run_cycle(); n++; end
    stuck[2] = 1'b0;
    refresh_inputs();
    n = 0;
    while (to_bnd(2) != 2 && n < 500) begin run_cycle(); n++; end
    sel = 3'd3;
    repeat (3) run_cycle();
    total++; if (switching !== 1'b1) begin bad++; $display("[TB] FAIL retarget_ignore_bnd2 got=%0b exp=1", switching); end
    wait_lock(3, "retarget_lock");
  endtask

  task automatic test_timeout();
    int gstart;
    int q[$];
    int p0, p1, p2;
    stuck[0] = 1'b1;
    refresh_inputs();
    sel = 3'd0;
    wait_gap("timeout");
    gstart = cyc;
    repeat (320) begin
      run_cycle();
      if (src_lost === 1'b1) q.push_back(cyc - gstart);
    end
    p0 = (q.size() > 0) ? q[0] : -1;
    p1 = (q.size() > 1) ? q[1] : -1;
    p2 = (q.size() > 2) ? q[2] : -1;
    total++; if (q.size() != 3) begin bad++; $display("[TB] FAIL timeout_count got=%0d exp=3", q.size()); end
    total++; if (p0 != 100) begin bad++; $display("[TB] FAIL timeout_first got=%0d exp=100", p0); end
    total++; if (p1 != 200) begin bad++; $display("[TB] FAIL timeout_second got=%0d exp=200", p1); end
    total++; if (p2 != 300) begin bad++; $display("[TB] FAIL timeout_third got=%0d exp=300", p2); end
    stuck[0] = 1'b0;
    refresh_inputs();
    wait_lock(0, "timeout_recover");
  endtask

  task automatic test_invalid_sel();
    sel = 3'd5;
    repeat (40) run_cycle();
    total++; if (switching !== 1'b0) begin bad++; $display("[TB] FAIL invalid5_switching got=%0b exp=0", switching); end
    total++; if (active_ch !== 3'd0) begin bad++; $display("[TB] FAIL invalid5_active got=%0d exp=0", active_ch); end
    sel = 3'd7;
    repeat (20) run_cycle();
    total++; if (switching !== 1'b0) begin bad++; $display("[TB] FAIL invalid7_switching got=%0b exp=0", switching); end
    sel = 3'd0;
  endtask

  task automatic test_midreset();
    sel = 3'd1;
    repeat (3) run_cycle();
    #2;
    reset = 1'b1;
    #1;
    total++; if (vs_o !== 1'b1) begin bad++; $display("[TB] FAIL midrst_vs got=%0b exp=1", vs_o); end
    total++; if (de_o !== 1'b0) begin bad++; $display("[TB] FAIL midrst_de got=%0b exp=0", de_o); end
    total++; if (data_o !== '0) begin bad++; $display("[TB] FAIL midrst_data got=%0h exp=0", data_o); end
    total++; if (switching !== 1'b1) begin bad++; $display("[TB] FAIL midrst_switching got=%0b exp=1", switching); end
    total++; if (active_ch !== '0) begin bad++; $display("[TB] FAIL midrst_active got=%0d exp=0", active_ch); end
    model_reset();
    repeat (2) begin @(posedge pix_clk); #1; advance_inputs(); end
    reset = 1'b0;
    wait_lock(1, "midrst_lock");
  endtask

  task automatic test_random();
    gap_de = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) sel = SW'($urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) begin
        int k;
        k = $urandom_range(0, N - 1);
        stuck[k] = !stuck[k];
        refresh_inputs();
      end
      run_cycle();
    end
    total++; if (gap_de !== 0) begin bad++; $display("[TB] FAIL random_gap_de got=%0d exp=0", gap_de); end
    for (int k = 0; k < N; k++) stuck[k] = 1'b0;
    refresh_inputs();
    sel = 3'd2;
    wait_lock(2, "random_final");
  endtask

  initial begin
    test_reset();
    test_switch();
    test_cancel();
    test_retarget();
    test_timeout();
    test_invalid_sel();
    test_midreset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL global_timeout got=%0d cycles exp=finish", cyc);
    $fatal(1, "[TB] run did not finish");
  end

endmodule
